// File: rtl/xintf_pkg.sv
// Shared encodings for the XINTF mirror engine: FSM state values and word widths.
package xintf_pkg;

    localparam int XINTF_WORD_W = 16;
    localparam int REG_W        = 32;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_LATCH = 2'd1,
        W_WRITE = 2'd2,
        W_GAP   = 2'd3
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_ISSUE  = 2'd1,
        R_DRAIN  = 2'd2,
        R_COMMIT = 2'd3
    } r_state_e;

endpackage

// File: rtl/xintf_hb_div.sv
// Commit-driven heartbeat divider: toggles o_hart_beat every HB_DIV commits and
// raises a sticky o_ready on the first commit.
module xintf_hb_div #(
    parameter int HB_DIV = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_commit,
    output logic o_ready,
    output logic o_hart_beat
);

    localparam int CNT_W = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HB_DIV - 1);

    if (HB_DIV < 1) begin : g_hb_div_chk
        $fatal(1, "xintf_hb_div: HB_DIV must be at least 1");
    end

    logic [CNT_W-1:0] hb_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            hb_cnt      <= '0;
            o_ready     <= 1'b0;
            o_hart_beat <= 1'b0;
        end else if (i_commit) begin
            o_ready <= 1'b1;
            if (hb_cnt == CNT_LAST) begin
                hb_cnt      <= '0;
                o_hart_beat <= ~o_hart_beat;
            end else begin
                hb_cnt <= hb_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/xintf_mirror_engine.sv
// XINTF register mirror: scans PS/ADC words into the PL-write DPBRAM and commits
// coherent snapshots of the PL-read DPBRAM. Option XINTF_MIRROR_SEQ_EN appends a
// scan-sequence word after each write scan.
module xintf_mirror_engine
    import xintf_pkg::*;
#(
    parameter int N_WR     = 26,
    parameter int N_RD     = 28,
    parameter int ADDR_W   = 9,
    parameter int WR_BASE  = 0,
    parameter int RD_BASE  = 0,
    parameter int SCAN_GAP = 4,
    parameter int HB_DIV   = 1000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [REG_W*N_WR-1:0]   i_wr_data,
    output logic [ADDR_W-1:0]       o_wr_ram_addr,
    output logic [XINTF_WORD_W-1:0] o_wr_ram_din,
    output logic                    o_wr_ram_we,
    output logic [ADDR_W-1:0]       o_rd_ram_addr,
    input  logic [XINTF_WORD_W-1:0] i_rd_ram_dout,
    output logic [REG_W*N_RD-1:0]   o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_ready,
    output logic                    o_hart_beat,
    output logic [15:0]             o_wr_scan_cnt,
    output logic [1:0]              o_w_state,
    output logic [1:0]              o_r_state
);

`ifdef XINTF_MIRROR_SEQ_EN
    localparam int SEQ_EXTRA = 1;
`else
    localparam int SEQ_EXTRA = 0;
`endif

    localparam int W_WORDS = 2 * N_WR + SEQ_EXTRA;
    localparam int WIDX_W  = $clog2(W_WORDS + 1);
    localparam logic [WIDX_W-1:0] W_LAST = WIDX_W'(W_WORDS - 1);

    localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((SCAN_GAP > 0) ? SCAN_GAP - 1 : 0);

    localparam int R_WORDS = 2 * N_RD;
    localparam int RIDX_W  = $clog2(R_WORDS + 1);
    localparam logic [RIDX_W-1:0] R_LAST = RIDX_W'(R_WORDS - 1);
    localparam int STAGE_W = REG_W * N_RD - XINTF_WORD_W;

    if (WR_BASE + W_WORDS > (1 << ADDR_W)) begin : g_wr_range_chk
        $fatal(1, "xintf_mirror_engine: write window exceeds PL-write BRAM");
    end
    if (RD_BASE + R_WORDS > (1 << ADDR_W)) begin : g_rd_range_chk
        $fatal(1, "xintf_mirror_engine: read window exceeds PL-read BRAM");
    end

    w_state_e                w_state, w_next;
    logic [WIDX_W-1:0]       w_idx;
    logic [GAP_W-1:0]        gap_cnt;
    logic [REG_W*N_WR-1:0]   wr_snap;
    logic [XINTF_WORD_W-1:0] wr_half;

    r_state_e                r_state, r_next;
    logic [RIDX_W-1:0]       r_idx;
    logic [STAGE_W-1:0]      rd_stage_p1;
    logic                    commit_load;

    // ---------------- write scan ----------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        wr_half = '0;
        for (int j = 0; j < 2 * N_WR; j++) begin
            if (w_idx == WIDX_W'(j)) wr_half = wr_snap[XINTF_WORD_W*j +: XINTF_WORD_W];
        end
`ifdef XINTF_MIRROR_SEQ_EN
        if (w_idx == WIDX_W'(2 * N_WR)) wr_half = o_wr_scan_cnt;
`endif
    end

    always_comb begin
        w_next        = w_state;
        o_wr_ram_addr = '0;
        o_wr_ram_din  = '0;
        o_wr_ram_we   = 1'b0;
        case (w_state)
            W_IDLE:  if (i_en) w_next = W_LATCH;
            W_LATCH: w_next = W_WRITE;
            W_WRITE: begin
                o_wr_ram_we   = 1'b1;
                o_wr_ram_addr = ADDR_W'(WR_BASE) + ADDR_W'(w_idx);
                o_wr_ram_din  = wr_half;
                if (w_idx == W_LAST) begin
                    if (SCAN_GAP > 0) w_next = W_GAP;
                    else if (i_en)    w_next = W_LATCH;
                    else              w_next = W_IDLE;
                end
            end
            W_GAP:   if (gap_cnt == GAP_LAST) w_next = i_en ? W_LATCH : W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            w_idx         <= '0;
            gap_cnt       <= '0;
            wr_snap       <= '0;
            o_wr_scan_cnt <= '0;
        end else begin
            w_idx   <= (w_state == W_WRITE) ? w_idx + 1'b1 : '0;
            gap_cnt <= (w_state == W_GAP) ? gap_cnt + 1'b1 : '0;
            // Whole vector captured in one cycle so a scan never mixes old and new inputs.
            if (w_state == W_LATCH) wr_snap <= i_wr_data;
            if (w_state == W_WRITE && w_idx == W_LAST) o_wr_scan_cnt <= o_wr_scan_cnt + 16'd1;
        end
    end

    // ---------------- read scan: address issue (p0) ----------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next        = r_state;
        o_rd_ram_addr = '0;
        case (r_state)
            R_IDLE:   if (i_en) r_next = R_ISSUE;
            R_ISSUE: begin
                o_rd_ram_addr = ADDR_W'(RD_BASE) + ADDR_W'(r_idx);
                if (r_idx == R_LAST) r_next = R_DRAIN;
            end
            R_DRAIN:  r_next = R_COMMIT;
            R_COMMIT: r_next = i_en ? R_ISSUE : R_IDLE;
            default:  r_next = R_IDLE;
        endcase
    end

    // ---------------- read scan: data capture (p1) and commit ----------------
    // The final half arrives during DRAIN and is folded straight into the commit
    // so the new snapshot is visible for the whole COMMIT cycle.
    assign commit_load = (r_state == R_DRAIN);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_idx       <= '0;
            rd_stage_p1 <= '0;
            o_rd_data   <= '0;
            o_rd_valid  <= 1'b0;
        end else begin
            r_idx      <= (r_state == R_ISSUE) ? r_idx + 1'b1 : '0;
            o_rd_valid <= commit_load;
            if (r_state == R_ISSUE) begin
                for (int j = 0; j < R_WORDS - 1; j++) begin
                    if (r_idx == RIDX_W'(j + 1))
                        rd_stage_p1[XINTF_WORD_W*j +: XINTF_WORD_W] <= i_rd_ram_dout;
                end
            end
            if (commit_load) o_rd_data <= {i_rd_ram_dout, rd_stage_p1};
        end
    end

    xintf_hb_div #(
        .HB_DIV (HB_DIV)
    ) u_hb_div (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_commit    (commit_load),
        .o_ready     (o_ready),
        .o_hart_beat (o_hart_beat)
    );

    assign o_w_state = w_state;
    assign o_r_state = r_state;

endmodule

// File: tb/tb_xintf_mirror_engine.sv
// Bench for xintf_mirror_engine (N_WR=N_RD=2, SCAN_GAP=0, HB_DIV=2): table of
// write/read scans checked through queue scoreboards, plus reset/coherency/heartbeat sequences.
module tb_xintf_mirror_engine;

    localparam int N_WR   = 2;
    localparam int N_RD   = 2;
    localparam int ADDR_W = 9;
    localparam int HB_DIV = 2;
`ifdef XINTF_MIRROR_SEQ_EN
    localparam int W_LEN = 5;
`else
    localparam int W_LEN = 4;
`endif
    localparam int W_PER = W_LEN + 1;
    localparam int R_PER = 2 * N_RD + 2;

    logic                clk;
    logic                rst_n;
    logic                i_en;
    logic [32*N_WR-1:0]  i_wr_data;
    logic [ADDR_W-1:0]   o_wr_ram_addr;
    logic [15:0]         o_wr_ram_din;
    logic                o_wr_ram_we;
    logic [ADDR_W-1:0]   o_rd_ram_addr;
    logic [15:0]         rd_dout;
    logic [32*N_RD-1:0]  o_rd_data;
    logic                o_rd_valid;
    logic                o_ready;
    logic                o_hart_beat;
    logic [15:0]         o_wr_scan_cnt;
    logic [1:0]          o_w_state;
    logic [1:0]          o_r_state;

    xintf_mirror_engine #(
        .N_WR(N_WR), .N_RD(N_RD), .ADDR_W(ADDR_W), .WR_BASE(0), .RD_BASE(0),
        .SCAN_GAP(0), .HB_DIV(HB_DIV)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_en(i_en), .i_wr_data(i_wr_data),
        .o_wr_ram_addr(o_wr_ram_addr), .o_wr_ram_din(o_wr_ram_din), .o_wr_ram_we(o_wr_ram_we),
        .o_rd_ram_addr(o_rd_ram_addr), .i_rd_ram_dout(rd_dout),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_ready(o_ready),
        .o_hart_beat(o_hart_beat), .o_wr_scan_cnt(o_wr_scan_cnt),
        .o_w_state(o_w_state), .o_r_state(o_r_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PL-read BRAM model: one-cycle latency, contents bram_ofs + address.
    logic [15:0] bram_ofs;
    always @(posedge clk) rd_dout <= bram_ofs + 16'(o_rd_ram_addr);

    logic [127:0] outs;
    assign outs = 128'({o_wr_ram_addr, o_wr_ram_din, o_wr_ram_we, o_rd_ram_addr, o_rd_data,
                        o_rd_valid, o_ready, o_hart_beat, o_wr_scan_cnt, o_w_state, o_r_state});

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       din;
    } wr_exp_t;

    typedef struct {
        logic [63:0] wr;
        logic [63:0] halves;   // expected din sequence, j=0 in the top 16 bits
        logic [15:0] ofs;
        int          h;        // cycles i_en is held high
    } vec_t;

    wr_exp_t     wq[$];
    logic [63:0] rq[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_wcnt;
    logic        mon_off;
    int          cyc = 0;
    int          commit_n;
    logic        hb_seen[8];
    int          vcyc[8];
    logic [63:0] prev_rd;
    logic        prev_vld;
    vec_t        vecs[4];

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int n_scans(int h, int per);
        return 1 + (h - 1) / per;
    endfunction

    task automatic push_wr_scan(input logic [63:0] halves);
        for (int j = 0; j < 4; j++)
            wq.push_back('{addr: ADDR_W'(j), din: halves[63-16*j -: 16]});
`ifdef XINTF_MIRROR_SEQ_EN
        wq.push_back('{addr: ADDR_W'(4), din: exp_wcnt});
`endif
        exp_wcnt = exp_wcnt + 16'd1;
    endtask

    task automatic push_rd_scan();
        rq.push_back({bram_ofs + 16'd3, bram_ofs + 16'd2, bram_ofs + 16'd1, bram_ofs});
    endtask

    task automatic run_en(input int h);
        @(negedge clk) i_en = 1'b1;
        repeat (h) @(posedge clk);
        @(negedge clk) i_en = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    task automatic settle_checks();
        check("wr_queue_left", 128'(wq.size()), 128'(0));
        check("rd_queue_left", 128'(rq.size()), 128'(0));
        check("wr_scan_cnt", 128'(o_wr_scan_cnt), 128'(exp_wcnt));
        check("ready_sticky", 128'(o_ready), 128'(1));
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", outs, 128'(0));
        rst_n = 1'b1;
        wq.delete();
        rq.delete();
        exp_wcnt = '0;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            commit_n = 0;
        end else if (!mon_off) begin
            if (o_wr_ram_we) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected_we", 128'(o_wr_ram_we), 128'(0));
                end else begin
                    wr_exp_t e;
                    e = wq.pop_front();
                    check("wr_addr", 128'(o_wr_ram_addr), 128'(e.addr));
                    check("wr_din", 128'(o_wr_ram_din), 128'(e.din));
                end
            end
            if (o_rd_data != prev_rd && !o_rd_valid)
                check("rd_data_changed_outside_commit", 128'(o_rd_data), 128'(prev_rd));
            if (o_rd_valid && prev_vld)
                check("rd_valid_single_pulse", 128'(o_rd_valid), 128'(0));
            if (o_rd_valid) begin
                if (rq.size() == 0) check("rd_unexpected_valid", 128'(o_rd_valid), 128'(0));
                else check("rd_data", 128'(o_rd_data), 128'(rq.pop_front()));
                check("ready_with_valid", 128'(o_ready), 128'(1));
                if (commit_n < 8) begin
                    hb_seen[commit_n] = o_hart_beat;
                    vcyc[commit_n]    = cyc;
                end
                commit_n++;
            end
        end
        prev_rd  = o_rd_data;
        prev_vld = o_rd_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        i_en      = 1'b0;
        i_wr_data = '0;
        bram_ofs  = 16'hA000;
        mon_off   = 1'b0;
        exp_wcnt  = '0;
        prev_rd   = '0;
        prev_vld  = 1'b0;
        commit_n  = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs, 128'(0));
        rst_n = 1'b1;

        // Reset asserted in the middle of a scan clears everything at once.
        @(negedge clk);
        mon_off   = 1'b1;
        i_wr_data = 64'hDEADBEEF_12345678;
        i_en      = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset_outputs", outs, 128'(0));
        i_en = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        wq.delete();
        rq.delete();
        exp_wcnt = '0;
        mon_off  = 1'b0;

        vecs[0] = '{64'hDEADBEEF_12345678, 64'h5678_1234_BEEF_DEAD, 16'hA000, 1};
        vecs[1] = '{64'h00000000_FFFFFFFF, 64'hFFFF_FFFF_0000_0000, 16'h1230, 1};
        vecs[2] = '{64'h0F0FA5A5_80017FFE, 64'h7FFE_8001_A5A5_0F0F, 16'hFFFC, 1};
        vecs[3] = '{64'hCAFEF00D_01234567, 64'h4567_0123_F00D_CAFE, 16'h0400, 7};

        for (int i = 0; i < 4; i++) begin
            i_wr_data = vecs[i].wr;
            bram_ofs  = vecs[i].ofs;
            repeat (n_scans(vecs[i].h, W_PER)) push_wr_scan(vecs[i].halves);
            repeat (n_scans(vecs[i].h, R_PER)) push_rd_scan();
            run_en(vecs[i].h);
            settle_checks();
        end

        // Input change right after LATCH must not reach the scan in progress.
        i_wr_data = 64'hDEADBEEF_12345678;
        bram_ofs  = 16'h5000;
        push_wr_scan(64'h5678_1234_BEEF_DEAD);
        push_wr_scan(64'h0);
        repeat (n_scans(W_LEN + 2, R_PER)) push_rd_scan();
        i_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) i_wr_data = '0;
        repeat (W_LEN) @(posedge clk);
        @(negedge clk) i_en = 1'b0;
        repeat (16) @(negedge clk);
        settle_checks();

        // Enable dropped at write index 1: scan finishes, then everything idles.
        i_wr_data = 64'h0BADF00D_13579BDF;
        bram_ofs  = 16'h2200;
        push_wr_scan(64'h9BDF_1357_F00D_0BAD);
        push_rd_scan();
        run_en(3);
        settle_checks();
        check("w_state_idle", 128'(o_w_state), 128'(0));
        check("r_state_idle", 128'(o_r_state), 128'(0));
        check("we_idle", 128'(o_wr_ram_we), 128'(0));
        push_wr_scan(64'h9BDF_1357_F00D_0BAD);
        push_rd_scan();
        run_en(1);
        settle_checks();

        // Heartbeat over four back-to-back read scans from a fresh reset.
        do_reset();
        i_wr_data = 64'h89ABCDEF_76543210;
        bram_ofs  = 16'h7770;
        repeat (n_scans(19, W_PER)) push_wr_scan(64'h3210_7654_CDEF_89AB);
        repeat (n_scans(19, R_PER)) push_rd_scan();
        run_en(19);
        settle_checks();
        check("commit_count", 128'(commit_n), 128'(4));
        check("hb_after_commit1", 128'(hb_seen[0]), 128'(0));
        check("hb_after_commit2", 128'(hb_seen[1]), 128'(1));
        check("hb_after_commit3", 128'(hb_seen[2]), 128'(1));
        check("hb_after_commit4", 128'(hb_seen[3]), 128'(0));
        for (int k = 1; k < 4; k++)
            check("rd_scan_period", 128'(vcyc[k] - vcyc[k-1]), 128'(R_PER));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/xintf_mirror_engine.md
Name: xintf_mirror_engine

Overview:
Parametrised successor to the fixed-map DSP XINTF register mirror. It scans N_WR 32-bit PS/ADC values into the PL-write DPBRAM as 16-bit word pairs. It also scans N_RD 32-bit values out of the PL-read DPBRAM, with coherent snapshot commit. Ready and heartbeat indications are generated from completed read scans. It sits between the AXI4-Lite register file and the XINTF dual-port BRAMs shared with the DSP.

Parameters:
N_WR, 26, number of 32-bit words mirrored PL->DSP
N_RD, 28, number of 32-bit words mirrored DSP->PL
ADDR_W, 9, DPBRAM word-address width
WR_BASE, 0, first PL-write BRAM address
RD_BASE, 0, first PL-read BRAM address
SCAN_GAP, 4, idle cycles between consecutive write scans (0 allowed)
HB_DIV, 1000, completed read scans per heartbeat toggle (>=1)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-low reset
i_en  in  1  scan enable (1 = Ethernet master connected)
i_wr_data  in  32*N_WR  flat write vector, word k at [32k+31:32k]
o_wr_ram_addr  out  ADDR_W  PL-write BRAM address
o_wr_ram_din  out  16  PL-write BRAM data
o_wr_ram_we  out  1  PL-write BRAM write enable
o_rd_ram_addr  out  ADDR_W  PL-read BRAM address
i_rd_ram_dout  in  16  PL-read BRAM data, 1-cycle read latency
o_rd_data  out  32*N_RD  committed read vector, same packing
o_rd_valid  out  1  1-cycle pulse on each commit
o_ready  out  1  high after first commit
o_hart_beat  out  1  heartbeat square wave
o_wr_scan_cnt  out  16  completed write scans, wraps
o_w_state  out  2  write FSM state (debug)
o_r_state  out  2  read FSM state (debug)

Behaviour:
- Reset (async assert, sync release): all outputs 0, both FSMs IDLE, staging and snapshot registers 0.
- Write FSM states: IDLE=0, LATCH=1, WRITE=2, GAP=3.
  - IDLE->LATCH when i_en=1.
  - LATCH, 1 cycle: snapshot the whole i_wr_data vector. Later input changes do not affect the current scan.
  - WRITE, 2*N_WR cycles, index j=0..2*N_WR-1: o_wr_ram_addr=WR_BASE+j; o_wr_ram_din=low half of word j/2 for even j, high half for odd j; o_wr_ram_we=1.
  - After the last word: o_wr_scan_cnt+1 (wraps at 16'hFFFF->0), go to GAP.
  - GAP, SCAN_GAP cycles, we=0. Then LATCH if i_en=1, else IDLE. SCAN_GAP=0 means WRITE goes directly to LATCH or IDLE.
- Read FSM states: IDLE=0, ISSUE=1, DRAIN=2, COMMIT=3.
  - IDLE->ISSUE when i_en=1.
  - ISSUE: o_rd_ram_addr=RD_BASE+j, j=0..2*N_RD-1, one address per cycle. Data for address j is captured one cycle later into staging (even j = low half, odd j = high half).
  - DRAIN, 1 cycle: capture the last word.
  - COMMIT, 1 cycle: copy staging to o_rd_data, pulse o_rd_valid, set o_ready, advance heartbeat divider. Then ISSUE if i_en=1, else IDLE.
  - Read scan period = 2*N_RD+2 cycles. o_rd_data changes only in the COMMIT cycle, never partially.
- i_en deassert mid-scan: both FSMs complete the current scan, including commit/count, then go IDLE. Re-assert restarts from index 0.
- Heartbeat: counter 0..HB_DIV-1 advances on each commit. On wrap, o_hart_beat toggles.
- o_ready: sticky; cleared only by reset.
- Elaboration check (fatal): WR_BASE+2*N_WR(+1 with option) <= 2**ADDR_W, and RD_BASE+2*N_RD <= 2**ADDR_W.

Optional Feature:
XINTF_MIRROR_SEQ_EN
- Defined: WRITE is extended by one cycle. Address WR_BASE+2*N_WR is written with the current o_wr_scan_cnt value (pre-increment), so the DSP can detect torn or stale frames.
- Undefined: no extra word; WRITE is exactly 2*N_WR cycles.

Decomposition:
- Package xintf_pkg: write FSM state encodings, read FSM state encodings, XINTF_WORD_W=16, REG_W=32.
- Natural sub-module xintf_hb_div: the commit-driven heartbeat divider and sticky-ready logic.
- Both FSMs stay in the top module.

Test Plan:
- Reset: hold i_rst=0 mid-scan -> every output is 0 immediately; after release and i_en=1, scanning starts at index 0.
- Write scan, N_WR=2, SCAN_GAP=0: i_wr_data={32'hDEADBEEF,32'h12345678} -> addr 0..3, din 5678,1234,BEEF,DEAD, we=1 for exactly 4 cycles; o_wr_scan_cnt=1.
- Coherency: change i_wr_data to all 32'h0 in the cycle after LATCH -> current scan still writes 5678,1234,BEEF,DEAD; the next scan writes 0s.
- Read commit, N_RD=2: BRAM model dout=16'hA000+addr -> o_rd_data={32'hA003A002,32'hA001A000}, updated only in the COMMIT cycle; o_rd_valid one pulse; o_ready rises with it; period 6 cycles.
- i_en drop at WRITE index 1 -> scan completes to index 3, count increments, then IDLE with we=0; re-enable -> new scan from addr 0.
- HB_DIV=2: o_hart_beat toggles after commits 2 and 4 -> 0,0,1,1,0. With XINTF_MIRROR_SEQ_EN: addr 4 receives 0 then 1 on successive write scans.
